mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits.
REQ-002 Parameter ADDR_W, default 8: word-index width; depth = 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states between acceptance and response, range 0..15.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 req_valid  input  1: initiator presents a request.
REQ-007 req_write  input  1: 1 = write, 0 = read.
REQ-008 req_addr  input  32: byte address.
REQ-009 req_wdata  input  DATA_W: write data.
REQ-010 req_ready  output  1: responder can accept a request this cycle.
REQ-011 resp_valid  output  1: response is available.
REQ-012 resp_rdata  output  DATA_W: read data.
REQ-013 resp_err  output  1: request was misaligned or out of range.
REQ-014 resp_ready  input  1: initiator consumes the response.

Function
REQ-015 FSM states are IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request is accepted on an edge where state is IDLE and req_valid=1; req_write, req_addr and req_wdata are latched on that edge.
REQ-017 On acceptance, the FSM goes to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise directly to RESP.
REQ-018 In WAIT, the counter decrements each cycle; at counter=0 the FSM goes to RESP.
REQ-019 resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 Error condition: req_addr[1:0]!=0, or req_addr[31:ADDR_W+2]!=0.
REQ-021 A valid write commits to the array on the edge entering RESP; an errored write SHALL NOT modify the array.
REQ-022 A valid read returns the word at req_addr[ADDR_W+1:2] as of entering RESP; an errored read returns resp_rdata=0.
REQ-023 resp_valid, resp_rdata and resp_err SHALL hold stable in RESP until resp_ready=1.
REQ-024 On an edge in RESP with resp_ready=1, the FSM returns to IDLE; the next request can be accepted no earlier than the following edge.
REQ-025 For writes, resp_rdata SHALL be 0.
REQ-026 req_valid while req_ready=0 is ignored; the initiator holds the request.
REQ-027 Outputs are registered or decoded from state only; there is no combinational path from req_* or resp_ready to any output.

Reset
REQ-028 Reset SHALL force IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0 on the next edge.
REQ-029 Reset in WAIT aborts the request; an uncommitted write SHALL NOT be committed.
REQ-030 Reset in RESP discards the pending response.
REQ-031 Array contents are not cleared by reset.
REQ-032 Reset has priority over acceptance in the same cycle.

Structure
REQ-033 FSM state encodings and the error-check constants SHALL reside in the shared package mem_bus_pkg.
REQ-034 Storage SHALL be a sub-module mem_array: synchronous write, registered read, DATA_W x 2**ADDR_W.
REQ-035 The FSM, counter and error check SHALL reside in mem_responder.

Verification
REQ-036 Write with WAIT_CYCLES=2: write addr 0x10, data 0xDEADBEEF, resp_ready=1 -> resp_valid rises 3 cycles after acceptance with resp_err=0 and resp_rdata=0; a following read of 0x10 returns 0xDEADBEEF.
REQ-037 Misaligned write: write 0x13 with 0x12345678 -> resp_err=1; a later read of 0x10 still returns the prior value.
REQ-038 Out-of-range read with ADDR_W=8: read 0x400 -> resp_err=1 and resp_rdata=0.
REQ-039 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stay stable and req_ready=0; after resp_ready=1, IDLE is reached on the next edge.
REQ-040 Reset mid-operation: assert reset in WAIT during a write of 0xA5A5A5A5 to 0x20 -> IDLE next edge with all outputs at reset values; a read of 0x20 returns the old value.
REQ-041 WAIT_CYCLES=0: back-to-back reads with resp_ready held at 1 -> resp_valid one cycle after each acceptance, and requests accepted every 2 cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory responder: FSM encoding and address-check helpers.
package mem_bus_pkg;

    localparam int unsigned BYTE_ADDR_W = 32;
    localparam int unsigned OFFSET_W    = 2;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A byte address is bad if it is not word aligned or reaches past the array depth.
    function automatic logic addr_err(input logic [BYTE_ADDR_W-1:0] addr,
                                      input int unsigned addr_w);
        logic [BYTE_ADDR_W-1:0] hi_mask;
        hi_mask = {BYTE_ADDR_W{1'b1}} << (addr_w + OFFSET_W);
        return (addr[OFFSET_W-1:0] != '0) || ((addr & hi_mask) != '0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Request/response memory target with a fixed number of wait states and address checking.
module mem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    input  logic              resp_ready
);

    import mem_bus_pkg::*;

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic              lat_err;
    logic [ADDR_W-1:0] lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic              rd_sel;

    logic              live_err_c;
    logic              cur_write_c;
    logic              cur_err_c;
    logic [ADDR_W-1:0] cur_idx_c;
    logic [DATA_W-1:0] cur_wdata_c;
    logic              enter_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic [DATA_W-1:0] arr_rdata;

    // With zero wait states the array is accessed on the acceptance edge, so use the live request.
    always_comb begin
        live_err_c  = addr_err(req_addr, ADDR_W);
        cur_write_c = lat_write;
        cur_err_c   = lat_err;
        cur_idx_c   = lat_idx;
        cur_wdata_c = lat_wdata;
        if (state == ST_IDLE) begin
            cur_write_c = req_write;
            cur_err_c   = live_err_c;
            cur_idx_c   = req_addr[ADDR_W+OFFSET_W-1:OFFSET_W];
            cur_wdata_c = req_wdata;
        end
        if (WAIT_CYCLES == 0) begin
            enter_c = (state == ST_IDLE) && req_valid;
        end else begin
            enter_c = (state == ST_WAIT) && (cnt == '0);
        end
        mem_we_c = enter_c && cur_write_c  && !cur_err_c && !reset;
        mem_re_c = enter_c && !cur_write_c && !cur_err_c && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_sel     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_err   <= live_err_c;
                        lat_idx   <= cur_idx_c;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= cur_err_c;
                            rd_sel     <= !cur_write_c && !cur_err_c;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= lat_err;
                        rd_sel     <= !lat_write && !lat_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rd_sel     <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Read data is only exposed for error-free reads; everything else reads as zero.
    assign resp_rdata = rd_sel ? arr_rdata : '0;

    mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we_c),
        .re   (mem_re_c),
        .addr (cur_idx_c),
        .wdata(cur_wdata_c),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Checks mem_responder against a word-array reference model: latency, errors, backpressure, reset, throughput.
module tb_mem_responder;

    localparam int unsigned W_A     = 2;
    localparam int unsigned AW_A    = 8;
    localparam int unsigned DEPTH_A = 2 ** AW_A;
    localparam int unsigned AW_B    = 4;
    localparam int unsigned DEPTH_B = 2 ** AW_B;

    logic clk;
    int   tests;
    int   fails;

    logic        a_reset, a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_err, a_resp_ready;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        b_reset, b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err, b_resp_ready;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    logic [31:0] amem [DEPTH_A];
    logic [31:0] bmem [DEPTH_B];

    mem_responder #(.DATA_W(32), .ADDR_W(AW_A), .WAIT_CYCLES(W_A)) u_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_ready(a_req_ready),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .resp_ready(a_resp_ready)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(AW_B), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .resp_ready(b_resp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err_a(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= 32'(4 * DEPTH_A));
    endfunction

    // One full transaction on instance A, holding off resp_ready for 'hold' cycles.
    task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        exp_err = model_err_a(addr);
        exp_rd  = (wr || exp_err) ? 32'h0 : amem[addr / 4];
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0; a_req_write = ~wr; a_req_addr = $urandom; a_req_wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_resp_valid && n < 30);
        chk("a_latency", 32'(n), 32'(W_A + 1));
        chk("a_err", 32'(a_resp_err), 32'(exp_err));
        chk("a_rdata", a_resp_rdata, exp_rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("a_hold_valid", 32'(a_resp_valid), 32'd1);
            chk("a_hold_rdata", a_resp_rdata, exp_rd);
            chk("a_hold_err", 32'(a_resp_err), 32'(exp_err));
            chk("a_hold_ready", 32'(a_req_ready), 32'd0);
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        chk("a_back_idle", {30'd0, a_req_ready, a_resp_valid}, 32'd2);
        if (wr && !exp_err) amem[addr / 4] = wd;
    endtask

    // Back-to-back traffic on the zero-wait instance with resp_ready held high.
    task automatic tput_b(input logic wr, input int n);
        int          last_acc;
        int          accepts;
        int          seq;
        logic [31:0] pend_addr;
        logic [31:0] pend_wd;
        last_acc = -10; accepts = 0; seq = 0;
        pend_addr = 0; pend_wd = 0;
        @(negedge clk);
        b_resp_ready = 1'b1; b_req_valid = 1'b1; b_req_write = wr;
        b_req_addr  = wr ? 32'h0 : 32'($urandom_range(0, DEPTH_B - 1) * 4);
        b_req_wdata = $urandom;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (b_resp_valid) begin
                chk("b_latency", 32'(i), 32'(last_acc + 1));
                chk("b_err", 32'(b_resp_err), 32'd0);
                chk("b_rdata", b_resp_rdata, wr ? 32'h0 : bmem[pend_addr / 4]);
                if (wr) bmem[pend_addr / 4] = pend_wd;
                seq++;
                b_req_addr  = wr ? 32'((seq % DEPTH_B) * 4) : 32'($urandom_range(0, DEPTH_B - 1) * 4);
                b_req_wdata = $urandom;
            end
            if (b_req_ready) begin
                if (last_acc >= 0) chk("b_rate", 32'(i - last_acc), 32'd2);
                last_acc  = i;
                accepts++;
                pend_addr = b_req_addr;
                pend_wd   = b_req_wdata;
            end
        end
        b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        b_resp_ready = 1'b0;
        chk("b_accepts", 32'(accepts), 32'(n / 2));
        chk("b_idle", {30'd0, b_req_ready, b_resp_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] addr;
        int          r;
        clk = 1'b0; tests = 0; fails = 0;
        a_reset = 1'b1; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 1'b0;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(a_req_ready), 32'd1);
        chk("rst_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_rdata", a_resp_rdata, 32'h0);
        chk("rst_err", 32'(a_resp_err), 32'd0);
        chk("rst_b_ready", 32'(b_req_ready), 32'd1);
        a_reset = 1'b0; b_reset = 1'b0;

        for (int i = 0; i < int'(DEPTH_A); i++) txn_a(1'b1, 32'(i * 4), $urandom, 0);

        txn_a(1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn_a(1'b0, 32'h10, 32'h0, 0);
        txn_a(1'b1, 32'h13, 32'h12345678, 0);
        txn_a(1'b0, 32'h10, 32'h0, 0);
        txn_a(1'b0, 32'h400, 32'h0, 0);
        txn_a(1'b0, 32'h10, 32'h0, 5);

        // Reset while a write sits in WAIT must drop it.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("mid_wait_ready", 32'(a_req_ready), 32'd0);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        chk("mid_rst_ready", 32'(a_req_ready), 32'd1);
        chk("mid_rst_valid", 32'(a_resp_valid), 32'd0);
        chk("mid_rst_rdata", a_resp_rdata, 32'h0);
        chk("mid_rst_err", 32'(a_resp_err), 32'd0);
        txn_a(1'b0, 32'h20, 32'h0, 0);

        // Reset beats a simultaneous request.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10; a_reset = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0; a_reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_prio_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_prio_ready", 32'(a_req_ready), 32'd1);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      addr = 32'($urandom_range(0, DEPTH_A - 1) * 4);
            else if (r < 8) addr = 32'($urandom_range(0, DEPTH_A - 1) * 4 + $urandom_range(1, 3));
            else            addr = 32'h400 << $urandom_range(0, 21);
            txn_a(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
        end

        tput_b(1'b1, 2 * DEPTH_B);
        tput_b(1'b0, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
